// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between the display side (master) and the binary-to-BCD
// converter (slave): start/bin request, busy/done status and packed BCD result.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                    start;
    logic [WIDTH-1:0]        bin;
    logic                    busy;
    logic                    done;
    logic [4*DIGITS-1:0]     bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional BIN_TO_BCD_AUTO_CONVERT_EN: also start whenever bin differs from the last accepted value.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   adj;
    logic               start_req;
`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
    logic [WIDTH-1:0]   last_bin_q, last_bin_d;
`endif

    // Each digit independently gets +3 when >= 5; no carry crosses digit boundaries.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        adj       = add3_digits(scratch_q);
`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
        last_bin_d = last_bin_q;
        start_req  = bus.start || (bus.bin != last_bin_q);
`else
        start_req  = bus.start;
`endif

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    work_d    = bus.bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = SHIFT;
`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
                    last_bin_d = bus.bin;
`endif
                end
            end
            SHIFT: begin
                scratch_d = {adj[BCD_W-2:0], work_q[WIDTH-1]};
                work_d    = {work_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                // Last shift: the shifted scratch is the final result.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = {adj[BCD_W-2:0], work_q[WIDTH-1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            work_q    <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
            last_bin_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
            last_bin_q <= last_bin_d;
`endif
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: expected BCD pushed at request, popped on done.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [11:0] sb[$];
    logic [11:0] mon_exp;

    bin_to_bcd_seq_if b_if ();

    bin_to_bcd_seq dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && b_if.done === 1'b1) begin
            done_cnt++;
            check_eq("done_has_pending_request", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                check_eq("bcd_result", b_if.bcd, mon_exp);
            end
        end
    end

    // Called just after the accepting edge; returns edges to done and busy cycles seen.
    task automatic wait_done(input logic [11:0] prev, output int lat, output int busy_n,
                             output bit held);
        lat = 0;
        busy_n = 0;
        held = 1'b1;
        while (b_if.done !== 1'b1 && lat < 20) begin
            if (b_if.busy === 1'b1) busy_n++;
            if (b_if.bcd !== prev) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic start_conv(input int v, input bit push);
        @(negedge clk);
        b_if.bin   = 8'(v);
        b_if.start = 1'b1;
        if (push) sb.push_back(to_bcd(v));
        @(posedge clk); #1;
        b_if.start = 1'b0;
    endtask

    task automatic post_done_checks(input int v);
        @(posedge clk); #1;
        check_eq("done_single_pulse", b_if.done, 1'b0);
        check_eq("busy_after_done", b_if.busy, 1'b0);
        check_eq("bcd_holds_result", b_if.bcd, to_bcd(v));
    endtask

    task automatic convert(input int v);
        logic [11:0] prev;
        int lat, busy_n;
        bit held;
        prev = b_if.bcd;
        start_conv(v, 1'b1);
        wait_done(prev, lat, busy_n, held);
        check_eq("latency", lat, 8);
        check_eq("busy_cycles", busy_n, 8);
        check_eq("bcd_stable_while_busy", held, 1'b1);
        post_done_checks(v);
    endtask

    initial begin
        int lat, busy_n, d0;
        bit held;
        int vals[6] = '{0, 9, 10, 99, 100, 128};

        rst_n      = 1'b0;
        b_if.start = 1'b1;
        b_if.bin   = 8'hAB;
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("reset_outputs", {b_if.busy, b_if.done, b_if.bcd}, 14'h0);
        end

        // Release with start held: accepted at the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(to_bcd(8'hAB));
        @(posedge clk); #1;
        b_if.start = 1'b0;
        wait_done(12'h000, lat, busy_n, held);
        check_eq("first_edge_latency", lat, 8);
        check_eq("first_edge_busy", busy_n, 8);
        post_done_checks(8'hAB);

        d0 = done_cnt;
        convert(255);
        check_eq("max_one_done", done_cnt - d0, 1);

        foreach (vals[i]) convert(vals[i]);
        repeat (3) convert(int'($urandom_range(0, 255)));

        // Start during SHIFT must be ignored.
        d0 = done_cnt;
        start_conv(200, 1'b1);
        repeat (3) @(negedge clk);
        b_if.bin   = 8'd7;
        b_if.start = 1'b1;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        b_if.bin   = 8'd200;
        repeat (25) @(posedge clk);
        #1;
        check_eq("ignored_start_done_count", done_cnt - d0, 1);
        check_eq("ignored_start_bcd", b_if.bcd, to_bcd(200));

        // Reset mid-conversion aborts with no done.
        d0 = done_cnt;
        start_conv(255, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b0;
        b_if.bin = 8'd0;
        #1;
        check_eq("abort_outputs", {b_if.busy, b_if.done, b_if.bcd}, 14'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_idle", {b_if.busy, b_if.bcd}, 13'h0);
        convert(42);

`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
        b_if.start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            d0 = done_cnt;
            @(negedge clk);
            b_if.bin = 8'(s);
            sb.push_back(to_bcd(s));
            repeat (40) @(posedge clk);
            #1;
            check_eq("auto_one_done", done_cnt - d0, 1);
            check_eq("auto_bcd", b_if.bcd, to_bcd(s));
        end
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check_eq("auto_hold_no_done", done_cnt - d0, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check_eq("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
